muldiv_ctrl: RTL and testbench



---
 rtl/muldiv_ctrl.sv | 170 +++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle sequencer for MULT/MULTU/DIV/DIVU and owner of
// the architectural HI/LO pair. Operands are latched on accept and held on
// the ALU inputs for MUL_CYCLES or DIV_CYCLES cycles. The ALU's 64-bit
// result is then committed to HI/LO.
//
// Handshake: start_i is a request-valid and ready_o is the matching ready.
// A request transfers on a rising edge where start_i=1 and ready_o=1.
// start_i seen while ready_o=0 is ignored, not queued, so the requester
// keeps start_i asserted until it observes ready_o=1. busy_o is the
// complement of ready_o and reflects the 1-bit FSM state directly.
module muldiv_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [4:0]  aluop_i,
    input  logic [31:0] src0_i,
    input  logic [31:0] src1_i,
    input  logic        mthi_we_i,
    input  logic        mtlo_we_i,
    input  logic [31:0] wdata_i,
    input  logic [63:0] alu_out_i,
    output logic [4:0]  alu_aluop_o,
    output logic [31:0] alu_src0_o,
    output logic [31:0] alu_src1_o,
    output logic        ready_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        div0_o,
    output logic        illegal_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    // Opcode values shared with the ALU's decode.
    localparam logic [4:0] ALUOP_ADD   = 5'd1;
    localparam logic [4:0] ALUOP_MULT  = 5'd12;
    localparam logic [4:0] ALUOP_MULTU = 5'd13;
    localparam logic [4:0] ALUOP_DIV   = 5'd14;
    localparam logic [4:0] ALUOP_DIVU  = 5'd15;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [4:0]  op_q;
    logic [31:0] src0_q;
    logic [31:0] src1_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;
    logic        div0_q;
    logic        illegal_q;

    logic        in_is_mul;
    logic        in_is_div;
    logic        in_legal;
    logic        accept;
    logic        q_is_div;
    logic        last_cycle;

    // Decode the incoming opcode and the latched opcode.
    always_comb begin
        in_is_mul  = (aluop_i == ALUOP_MULT) || (aluop_i == ALUOP_MULTU);
        in_is_div  = (aluop_i == ALUOP_DIV)  || (aluop_i == ALUOP_DIVU);
        in_legal   = in_is_mul || in_is_div;
        accept     = (state == IDLE) && start_i && in_legal;
        q_is_div   = (op_q == ALUOP_DIV) || (op_q == ALUOP_DIVU);
        last_cycle = (state == RUN) && (cnt == 4'd0);
    end

    // Next-state logic: IDLE -> RUN on accept, RUN -> IDLE when cnt hits 0.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (cnt == 4'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Operand latch and cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= 5'd0;
            src0_q <= 32'd0;
            src1_q <= 32'd0;
            cnt    <= 4'd0;
        end else if (accept) begin
            op_q   <= aluop_i;
            src0_q <= src0_i;
            src1_q <= src1_i;
            cnt    <= in_is_mul ? MUL_LOAD : DIV_LOAD;
        end else if ((state == RUN) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    // HI/LO: commit on the last RUN edge, MTHI/MTLO only in IDLE without accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (last_cycle) begin
            if (!(q_is_div && (src1_q == 32'd0))) begin
                hi_q <= alu_out_i[63:32];
                lo_q <= alu_out_i[31:0];
            end
        end else if ((state == IDLE) && !accept) begin
            if (mthi_we_i) hi_q <= wdata_i;
            if (mtlo_we_i) lo_q <= wdata_i;
        end
    end

    // Registered one-cycle status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q    <= 1'b0;
            div0_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            done_q    <= last_cycle;
            div0_q    <= last_cycle && q_is_div && (src1_q == 32'd0);
            illegal_q <= (state == IDLE) && start_i && !in_legal;
        end
    end

    // ALU drive: latched values in RUN, the ALU's default case otherwise.
    always_comb begin
        alu_aluop_o = 5'd0;
        alu_src0_o  = 32'd0;
        alu_src1_o  = 32'd0;
        if (state == RUN) begin
            alu_aluop_o = op_q;
            alu_src0_o  = src0_q;
            alu_src1_o  = src1_q;
        end
    end

    // Status and register outputs.
    always_comb begin
        ready_o   = (state == IDLE);
        busy_o    = (state == RUN);
        done_o    = done_q;
        div0_o    = div0_q;
        illegal_o = illegal_q;
        hi_o      = hi_q;
        lo_o      = lo_q;
    end

    // ALUOP_ADD is kept for documentation of the illegal-opcode path.
    logic unused_add;
    assign unused_add = ^ALUOP_ADD;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed and randomized checks of muldiv_ctrl against a
// behavioural HI/LO model and a stand-in combinational ALU.
module tb_muldiv_ctrl;

  localparam int MUL_CYCLES = 4;
  localparam int DIV_CYCLES = 8;

  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_MULT  = 5'd12;
  localparam logic [4:0] OP_MULTU = 5'd13;
  localparam logic [4:0] OP_DIV   = 5'd14;
  localparam logic [4:0] OP_DIVU  = 5'd15;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [4:0]  aluop_i;
  logic [31:0] src0_i;
  logic [31:0] src1_i;
  logic        mthi_we_i;
  logic        mtlo_we_i;
  logic [31:0] wdata_i;
  logic [63:0] alu_out_i;
  logic [4:0]  alu_aluop_o;
  logic [31:0] alu_src0_o;
  logic [31:0] alu_src1_o;
  logic        ready_o;
  logic        busy_o;
  logic        done_o;
  logic        div0_o;
  logic        illegal_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_checks;
  int n_pass;
  int n_fail;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  muldiv_ctrl #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .aluop_i     (aluop_i),
    .src0_i      (src0_i),
    .src1_i      (src1_i),
    .mthi_we_i   (mthi_we_i),
    .mtlo_we_i   (mtlo_we_i),
    .wdata_i     (wdata_i),
    .alu_out_i   (alu_out_i),
    .alu_aluop_o (alu_aluop_o),
    .alu_src0_o  (alu_src0_o),
    .alu_src1_o  (alu_src1_o),
    .ready_o     (ready_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .div0_o      (div0_o),
    .illegal_o   (illegal_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "time limit reached");
  end

  // Behavioural result of an operation: {hi, lo} per MIPS semantics.
  function automatic logic [63:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0] up;
    case (op)
      OP_MULT: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return sp;
      end
      OP_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        return up;
      end
      OP_DIV: begin
        if (b == 32'd0) return 64'hBAD0_BAD0_BAD0_BAD0;
        return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      end
      OP_DIVU: begin
        if (b == 32'd0) return 64'hBAD0_BAD0_BAD0_BAD0;
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Stand-in combinational ALU fed from the DUT's ALU drive.
  always_comb begin
    alu_out_i = ref_result(alu_aluop_o, alu_src0_o, alu_src1_o);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s mismatched", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] rand_legal_op();
    case ($urandom_range(0, 3))
      0:       return OP_MULT;
      1:       return OP_MULTU;
      2:       return OP_DIV;
      default: return OP_DIVU;
    endcase
  endfunction

  function automatic logic [4:0] rand_illegal_op();
    logic [4:0] op;
    op = 5'($urandom_range(0, 31));
    while (op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU)
      op = 5'($urandom_range(0, 31));
    return op;
  endfunction

  task automatic clear_inputs();
    start_i   = 1'b0;
    aluop_i   = 5'd0;
    src0_i    = 32'd0;
    src1_i    = 32'd0;
    mthi_we_i = 1'b0;
    mtlo_we_i = 1'b0;
    wdata_i   = 32'd0;
  endtask

  // Issue one op from IDLE and follow it to done. With noise set, inputs
  // are scrambled during RUN (operands, start, moves).
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit noise);
    int k;
    bit dz;
    logic [63:0] r;
    k  = (op == OP_MULT || op == OP_MULTU) ? MUL_CYCLES : DIV_CYCLES;
    dz = (op == OP_DIV || op == OP_DIVU) && (b == 32'd0);
    chk("ready_before_start", 64'(ready_o), 64'd1);
    start_i = 1'b1;
    aluop_i = op;
    src0_i  = a;
    src1_i  = b;
    tick();
    clear_inputs();
    for (int i = 0; i < k; i++) begin
      chk("run_busy", 64'(busy_o), 64'd1);
      chk("run_ready", 64'(ready_o), 64'd0);
      chk("run_done", 64'(done_o), 64'd0);
      chk("run_illegal", 64'(illegal_o), 64'd0);
      chk("run_aluop", 64'(alu_aluop_o), 64'(op));
      chk("run_src0", 64'(alu_src0_o), 64'(a));
      chk("run_src1", 64'(alu_src1_o), 64'(b));
      chk("run_hi_held", 64'(hi_o), 64'(exp_hi));
      chk("run_lo_held", 64'(lo_o), 64'(exp_lo));
      if (noise) begin
        src0_i    = $urandom;
        src1_i    = $urandom;
        start_i   = 1'($urandom_range(0, 1));
        aluop_i   = ($urandom_range(0, 1) == 1) ? rand_legal_op() : rand_illegal_op();
        mthi_we_i = 1'($urandom_range(0, 1));
        mtlo_we_i = 1'($urandom_range(0, 1));
        wdata_i   = $urandom;
      end
      tick();
    end
    clear_inputs();
    if (!dz) begin
      r = ref_result(op, a, b);
      exp_hi = r[63:32];
      exp_lo = r[31:0];
    end
    chk("done_pulse", 64'(done_o), 64'd1);
    chk("div0_pulse", 64'(div0_o), 64'(dz));
    chk("done_busy", 64'(busy_o), 64'd0);
    chk("done_ready", 64'(ready_o), 64'd1);
    chk("commit_hi", 64'(hi_o), 64'(exp_hi));
    chk("commit_lo", 64'(lo_o), 64'(exp_lo));
  endtask

  // Idle cycle with pulses expected low.
  task automatic idle_cycle();
    tick();
    chk("idle_done", 64'(done_o), 64'd0);
    chk("idle_div0", 64'(div0_o), 64'd0);
    chk("idle_busy", 64'(busy_o), 64'd0);
    chk("idle_aluop", 64'(alu_aluop_o), 64'd0);
    chk("idle_src0", 64'(alu_src0_o), 64'd0);
  endtask

  task automatic mt_write(input bit whi, input bit wlo, input logic [31:0] d);
    mthi_we_i = whi;
    mtlo_we_i = wlo;
    wdata_i   = d;
    tick();
    clear_inputs();
    if (whi) exp_hi = d;
    if (wlo) exp_lo = d;
    chk("mt_hi", 64'(hi_o), 64'(exp_hi));
    chk("mt_lo", 64'(lo_o), 64'(exp_lo));
    chk("mt_busy", 64'(busy_o), 64'd0);
  endtask

  task automatic illegal_start(input logic [4:0] op);
    start_i = 1'b1;
    aluop_i = op;
    src0_i  = $urandom;
    src1_i  = $urandom;
    tick();
    clear_inputs();
    chk("illegal_pulse", 64'(illegal_o), 64'd1);
    chk("illegal_busy", 64'(busy_o), 64'd0);
    chk("illegal_ready", 64'(ready_o), 64'd1);
    chk("illegal_hi", 64'(hi_o), 64'(exp_hi));
    chk("illegal_lo", 64'(lo_o), 64'(exp_lo));
    tick();
    chk("illegal_one_cycle", 64'(illegal_o), 64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
    exp_hi   = 32'd0;
    exp_lo   = 32'd0;
    clear_inputs();

    // Reset.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_ready", 64'(ready_o), 64'd1);
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_done", 64'(done_o), 64'd0);
    chk("reset_div0", 64'(div0_o), 64'd0);
    chk("reset_illegal", 64'(illegal_o), 64'd0);
    chk("reset_hi", 64'(hi_o), 64'd0);
    chk("reset_lo", 64'(lo_o), 64'd0);
    chk("reset_aluop", 64'(alu_aluop_o), 64'd0);

    // MULT -3 * 5.
    do_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
    chk("mult_neg_hi", 64'(hi_o), 64'h0000_0000_FFFF_FFFF);
    chk("mult_neg_lo", 64'(lo_o), 64'h0000_0000_FFFF_FFF1);
    idle_cycle();

    // DIVU 7/2 then MULTU back-to-back from the done cycle.
    do_op(OP_DIVU, 32'd7, 32'd2, 1'b0);
    chk("divu_lo", 64'(lo_o), 64'd3);
    chk("divu_hi", 64'(hi_o), 64'd1);
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("multu_hi", 64'(hi_o), 64'd1);
    chk("multu_lo", 64'(lo_o), 64'h0000_0000_FFFF_FFFE);
    idle_cycle();

    // MTHI, MTLO, then divide by zero leaves them intact.
    mt_write(1'b1, 1'b0, 32'h0000_1234);
    mt_write(1'b0, 1'b1, 32'h0000_5678);
    do_op(OP_DIV, 32'd10, 32'd0, 1'b0);
    chk("div0_hi_kept", 64'(hi_o), 64'h1234);
    chk("div0_lo_kept", 64'(lo_o), 64'h5678);
    idle_cycle();
    chk("div0_one_cycle", 64'(div0_o), 64'd0);

    // Noise during a MULT RUN.
    do_op(OP_MULT, 32'd1000, 32'hFFFF_FF00, 1'b1);
    idle_cycle();

    // Illegal opcode in IDLE.
    illegal_start(OP_ADD);

    // Both moves at once.
    mt_write(1'b1, 1'b1, 32'hCAFE_F00D);

    // Start accepted in the same cycle as a move: move is dropped.
    mthi_we_i = 1'b1;
    mtlo_we_i = 1'b1;
    wdata_i   = 32'hDEAD_BEEF;
    do_op(OP_MULTU, 32'd3, 32'd4, 1'b0);
    chk("start_wins_hi", 64'(hi_o), 64'd0);
    chk("start_wins_lo", 64'(lo_o), 64'd12);
    idle_cycle();

    // Randomized mix against the model.
    for (int it = 0; it < 60; it++) begin
      int act;
      int gap;
      logic [4:0] op;
      logic [31:0] b;
      act = $urandom_range(0, 9);
      if (act <= 1) begin
        mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      end else if (act == 2) begin
        illegal_start(rand_illegal_op());
      end else begin
        op = rand_legal_op();
        b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
        do_op(op, $urandom, b, 1'($urandom_range(0, 1)));
      end
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle_cycle();
    end

    // Reset two cycles into a DIV RUN.
    idle_cycle();
    start_i = 1'b1;
    aluop_i = OP_DIV;
    src0_i  = 32'd100;
    src1_i  = 32'd7;
    tick();
    clear_inputs();
    tick();
    chk("pre_abort_busy", 64'(busy_o), 64'd1);
    rst = 1'b1;
    #1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    chk("abort_ready", 64'(ready_o), 64'd1);
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_hi", 64'(hi_o), 64'd0);
    chk("abort_lo", 64'(lo_o), 64'd0);
    chk("abort_done", 64'(done_o), 64'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < DIV_CYCLES + 4; i++) idle_cycle();
    chk("abort_hi_final", 64'(hi_o), 64'd0);
    chk("abort_lo_final", 64'(lo_o), 64'd0);

    // One more op after the abort.
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
